// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported instruction/data memory between the fetch stage
// (IF) and the memory stage (D). Each access takes LAT cycles. The arbiter
// drives the select of the address/data muxes in front of the memory. When
// it completes an access it returns the read data with a one-cycle ack to
// the requester that won.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_if_req     fetch request, held until o_if_ack
//   i_if_addr    fetch address
//   i_d_req      data request, held until o_d_ack
//   i_d_we       data write enable (1 = store, 0 = load)
//   i_d_addr     data address
//   i_d_wdata    store data
//   i_mem_rdata  memory read data
//   o_mem_en     memory access enable
//   o_mem_we     memory write enable
//   o_mem_addr   registered memory address
//   o_mem_wdata  registered memory write data
//   o_addr_sel   mux select, 0 = IF, 1 = D
//   o_if_ack     one-cycle fetch completion pulse
//   o_if_rdata   fetch data, valid with o_if_ack
//   o_d_ack      one-cycle data completion pulse
//   o_d_rdata    load data, valid with o_d_ack on a load
//   o_stall_if   fetch stage must wait
//   o_busy       an access is in progress
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int N   = 32,
  parameter int LAT = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_if_req,
  input  logic [N-1:0] i_if_addr,
  input  logic         i_d_req,
  input  logic         i_d_we,
  input  logic [N-1:0] i_d_addr,
  input  logic [N-1:0] i_d_wdata,
  input  logic [N-1:0] i_mem_rdata,
  output logic         o_mem_en,
  output logic         o_mem_we,
  output logic [N-1:0] o_mem_addr,
  output logic [N-1:0] o_mem_wdata,
  output logic         o_addr_sel,
  output logic         o_if_ack,
  output logic [N-1:0] o_if_rdata,
  output logic         o_d_ack,
  output logic [N-1:0] o_d_rdata,
  output logic         o_stall_if,
  output logic         o_busy
);

  localparam int            CW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_last_grant;
  logic           r_mem_en;
  logic           r_mem_we;
  logic [N-1:0]   r_mem_addr;
  logic [N-1:0]   r_mem_wdata;
  logic           r_addr_sel;
  logic           r_busy;

  logic           w_done;
  logic           w_decide;
  logic           w_if_pend;
  logic           w_d_pend;
  logic           w_grant_any;
  logic           w_grant_d;

  // The completion cycle is the one in which the down-counter reaches zero.
  assign w_done   = (r_state != IDLE) && (r_cnt == '0);
  assign w_decide = (r_state == IDLE) || w_done;

  // A requester's request is still high in its own ack cycle. It counts as
  // served at that edge, so it does not win a second, duplicate access.
  assign w_if_pend = i_if_req && !(w_done && (r_state == BUSY_I));
  assign w_d_pend  = i_d_req  && !(w_done && (r_state == BUSY_D));

  // On a tie the winner is the requester that did not win last time. The
  // reset value of last_grant is IF, so D wins the first tie.
  assign w_grant_any = w_if_pend || w_d_pend;
  assign w_grant_d   = w_d_pend && (!w_if_pend || !r_last_grant);

  // Sequencing register set. A grant loads the winner's access into the
  // memory-side registers. The counter then runs down to the completion
  // cycle. At that edge the next grant can be taken with no idle bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_addr_sel   <= 1'b0;
      r_busy       <= 1'b0;
    end else if (w_decide) begin
      if (w_grant_any) begin
        r_state      <= w_grant_d ? BUSY_D : BUSY_I;
        r_cnt        <= CNT_LOAD;
        r_last_grant <= w_grant_d;
        r_mem_en     <= 1'b1;
        r_busy       <= 1'b1;
        r_addr_sel   <= w_grant_d;
        if (w_grant_d) begin
          r_mem_addr  <= i_d_addr;
          r_mem_wdata <= i_d_wdata;
          r_mem_we    <= i_d_we;
        end else begin
          // Fetches never write. The write-data register keeps its value.
          r_mem_addr  <= i_if_addr;
          r_mem_we    <= 1'b0;
        end
      end else begin
        // Going idle: the address register keeps its value for observability.
        r_state  <= IDLE;
        r_mem_en <= 1'b0;
        r_mem_we <= 1'b0;
        r_busy   <= 1'b0;
      end
    end else begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_addr_sel  = r_addr_sel;
  assign o_busy      = r_busy;

  // The acks and the read data are combinational in the completion cycle.
  // Outside that cycle the read-data ports are forced to zero.
  assign o_if_ack   = w_done && (r_state == BUSY_I);
  assign o_d_ack    = w_done && (r_state == BUSY_D);
  assign o_if_rdata = o_if_ack ? i_mem_rdata : '0;
  assign o_d_rdata  = (o_d_ack && !r_mem_we) ? i_mem_rdata : '0;
  assign o_stall_if = i_if_req && !o_if_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. It has two instances: the default
// LAT=2 build, and a LAT=1 build for the back-to-back case. The memory is a
// combinational lookup that the bench also uses to compute expected data.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;

  logic        ifReq, dReq, dWe;
  logic [31:0] ifAddr, dAddr, dWdata, memRdata;
  logic        memEn, memWe, addrSel, ifAck, dAck, stallIf, busy;
  logic [31:0] memAddr, memWdata, ifRdata, dRdata;

  logic        if1Req, d1Req;
  logic [31:0] if1Addr, d1Addr, mem1Rdata;
  logic        mem1En, mem1We, addr1Sel, if1Ack, d1Ack, stall1If, busy1;
  logic [31:0] mem1Addr, mem1Wdata, if1Rdata, d1Rdata;

  int vectors;
  int miscompares;

  // Memory contents: one fixed instruction word, otherwise a function of the address.
  function automatic logic [31:0] memModel(input logic [31:0] a);
    if (a == 32'h40) return 32'h0050_0093;
    return a ^ 32'h5A5A_0000;
  endfunction

  assign memRdata  = memModel(memAddr);
  assign mem1Rdata = memModel(mem1Addr);

  mem_port_arbiter #(.N(32), .LAT(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(ifReq), .i_if_addr(ifAddr),
    .i_d_req(dReq), .i_d_we(dWe), .i_d_addr(dAddr), .i_d_wdata(dWdata),
    .i_mem_rdata(memRdata),
    .o_mem_en(memEn), .o_mem_we(memWe), .o_mem_addr(memAddr), .o_mem_wdata(memWdata),
    .o_addr_sel(addrSel), .o_if_ack(ifAck), .o_if_rdata(ifRdata),
    .o_d_ack(dAck), .o_d_rdata(dRdata), .o_stall_if(stallIf), .o_busy(busy)
  );

  mem_port_arbiter #(.N(32), .LAT(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if1Req), .i_if_addr(if1Addr),
    .i_d_req(d1Req), .i_d_we(1'b0), .i_d_addr(d1Addr), .i_d_wdata(32'h0),
    .i_mem_rdata(mem1Rdata),
    .o_mem_en(mem1En), .o_mem_we(mem1We), .o_mem_addr(mem1Addr), .o_mem_wdata(mem1Wdata),
    .o_addr_sel(addr1Sel), .o_if_ack(if1Ack), .o_if_rdata(if1Rdata),
    .o_d_ack(d1Ack), .o_d_rdata(d1Rdata), .o_stall_if(stall1If), .o_busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    tick();
    tick();
    vectors++;
    if ({memEn, memWe, addrSel, ifAck, dAck, busy} !== 6'b0 ||
        memAddr !== 32'h0 || memWdata !== 32'h0 || ifRdata !== 32'h0 || dRdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got en=%b we=%b sel=%b ia=%b da=%b busy=%b addr=%h wd=%h, expected all 0",
               memEn, memWe, addrSel, ifAck, dAck, busy, memAddr, memWdata);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0 || memEn !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: got busy=%b en=%b, expected 0 0", busy, memEn);
    end
  endtask

  task automatic test_single_fetch;
    ifReq = 1'b1; ifAddr = 32'h40;
    tick();
    vectors++;
    if (memEn !== 1'b1 || addrSel !== 1'b0 || memAddr !== 32'h40 || ifAck !== 1'b0 || stallIf !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL fetch_cycle1: got en=%b sel=%b addr=%h ack=%b stall=%b busy=%b, expected 1 0 00000040 0 1 1",
               memEn, addrSel, memAddr, ifAck, stallIf, busy);
    end
    tick();
    vectors++;
    if (ifAck !== 1'b1 || ifRdata !== 32'h0050_0093 || stallIf !== 1'b0 || memEn !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL fetch_cycle2: got ack=%b rdata=%h stall=%b en=%b, expected 1 00500093 0 1",
               ifAck, ifRdata, stallIf, memEn);
    end
    ifReq = 1'b0;
    tick();
    vectors++;
    if (memEn !== 1'b0 || busy !== 1'b0 || ifAck !== 1'b0 || memAddr !== 32'h40) begin
      miscompares++;
      $display("[TB] FAIL fetch_done: got en=%b busy=%b ack=%b addr=%h, expected 0 0 0 00000040",
               memEn, busy, ifAck, memAddr);
    end
  endtask

  task automatic test_simultaneous;
    pulseReset();
    ifReq = 1'b1; ifAddr = 32'h44;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h1000;
    tick();
    vectors++;
    if (addrSel !== 1'b1 || memAddr !== 32'h1000 || memWe !== 1'b0 || dAck !== 1'b0 || stallIf !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL simul_dgrant: got sel=%b addr=%h we=%b dack=%b stall=%b, expected 1 00001000 0 0 1",
               addrSel, memAddr, memWe, dAck, stallIf);
    end
    tick();
    vectors++;
    if (dAck !== 1'b1 || dRdata !== memModel(32'h1000) || ifAck !== 1'b0 || ifRdata !== 32'h0 || stallIf !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL simul_dack: got dack=%b drdata=%h iack=%b irdata=%h stall=%b, expected 1 %h 0 0 1",
               dAck, dRdata, ifAck, ifRdata, stallIf, memModel(32'h1000));
    end
    dReq = 1'b0;
    tick();
    vectors++;
    if (addrSel !== 1'b0 || memAddr !== 32'h44 || memEn !== 1'b1 || dAck !== 1'b0 || stallIf !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL simul_igrant: got sel=%b addr=%h en=%b dack=%b stall=%b, expected 0 00000044 1 0 1",
               addrSel, memAddr, memEn, dAck, stallIf);
    end
    tick();
    vectors++;
    if (ifAck !== 1'b1 || ifRdata !== memModel(32'h44) || stallIf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL simul_iack: got ack=%b rdata=%h stall=%b, expected 1 %h 0",
               ifAck, ifRdata, stallIf, memModel(32'h44));
    end
    ifReq = 1'b0;
    tick();
  endtask

  task automatic test_alternation;
    logic expectD;
    int   acks;
    int   cycles;
    ifReq = 1'b1; ifAddr = 32'h100;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h3000;
    expectD = 1'b1;
    acks = 0;
    cycles = 0;
    while (acks < 8 && cycles < 60) begin
      tick();
      cycles++;
      vectors++;
      if (ifAck && dAck) begin
        miscompares++;
        $display("[TB] FAIL alt_overlap: got if_ack=1 d_ack=1, expected at most one");
      end
      if (ifAck || dAck) begin
        vectors++;
        if (dAck !== expectD) begin
          miscompares++;
          $display("[TB] FAIL alt_order: ack %0d got d_ack=%b, expected %b", acks, dAck, expectD);
        end
        if (dAck) begin
          vectors++;
          if (dRdata !== memModel(dAddr)) begin
            miscompares++;
            $display("[TB] FAIL alt_drdata: got %h expected %h", dRdata, memModel(dAddr));
          end
          dAddr = dAddr + 32'd4;
        end else begin
          vectors++;
          if (ifRdata !== memModel(ifAddr)) begin
            miscompares++;
            $display("[TB] FAIL alt_irdata: got %h expected %h", ifRdata, memModel(ifAddr));
          end
          ifAddr = ifAddr + 32'd4;
        end
        expectD = !expectD;
        acks++;
      end
    end
    vectors++;
    if (acks != 8) begin
      miscompares++;
      $display("[TB] FAIL alt_timeout: got %0d acks, expected 8", acks);
    end
    ifReq = 1'b0;
    dReq = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_store;
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h2000; dWdata = 32'hDEAD_BEEF;
    tick();
    vectors++;
    if (memWe !== 1'b1 || memAddr !== 32'h2000 || memWdata !== 32'hDEAD_BEEF || addrSel !== 1'b1 || memEn !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL store_grant: got we=%b addr=%h wd=%h sel=%b en=%b, expected 1 00002000 deadbeef 1 1",
               memWe, memAddr, memWdata, addrSel, memEn);
    end
    dReq = 1'b0; dWe = 1'b0; dWdata = 32'h0;
    tick();
    vectors++;
    if (dAck !== 1'b1 || dRdata !== 32'h0 || memWe !== 1'b1 || memWdata !== 32'hDEAD_BEEF || ifAck !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL store_ack: got dack=%b drdata=%h we=%b wd=%h iack=%b, expected 1 0 1 deadbeef 0",
               dAck, dRdata, memWe, memWdata, ifAck);
    end
    tick();
    vectors++;
    if (memEn !== 1'b0 || memWe !== 1'b0 || busy !== 1'b0 || dAck !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL store_done: got en=%b we=%b busy=%b dack=%b, expected 0 0 0 0",
               memEn, memWe, busy, dAck);
    end
  endtask

  task automatic test_reset_mid_access;
    ifReq = 1'b1; ifAddr = 32'h80;
    tick();
    vectors++;
    if (memEn !== 1'b1 || memAddr !== 32'h80) begin
      miscompares++;
      $display("[TB] FAIL midrst_start: got en=%b addr=%h, expected 1 00000080", memEn, memAddr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({memEn, memWe, addrSel, ifAck, dAck, busy} !== 6'b0 ||
        memAddr !== 32'h0 || memWdata !== 32'h0 || ifRdata !== 32'h0 || dRdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL midrst_async: got en=%b we=%b sel=%b ia=%b da=%b busy=%b addr=%h wd=%h, expected all 0",
               memEn, memWe, addrSel, ifAck, dAck, busy, memAddr, memWdata);
    end
    tick();
    vectors++;
    if (ifAck !== 1'b0 || memEn !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_noack: got ack=%b en=%b, expected 0 0", ifAck, memEn);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (memEn !== 1'b1 || memAddr !== 32'h80 || ifAck !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_regrant: got en=%b addr=%h ack=%b, expected 1 00000080 0", memEn, memAddr, ifAck);
    end
    tick();
    vectors++;
    if (ifAck !== 1'b1 || ifRdata !== memModel(32'h80)) begin
      miscompares++;
      $display("[TB] FAIL midrst_ack: got ack=%b rdata=%h, expected 1 %h", ifAck, ifRdata, memModel(32'h80));
    end
    ifReq = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    logic expectD;
    if1Req = 1'b1; if1Addr = 32'h200;
    d1Req = 1'b1; d1Addr = 32'h4000;
    expectD = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (mem1En !== 1'b1 || (if1Ack ^ d1Ack) !== 1'b1 || d1Ack !== expectD) begin
        miscompares++;
        $display("[TB] FAIL b2b_cycle%0d: got en=%b if_ack=%b d_ack=%b, expected en=1 d_ack=%b if_ack=%b",
                 i, mem1En, if1Ack, d1Ack, expectD, !expectD);
      end
      if (if1Ack) begin
        vectors++;
        if (if1Rdata !== memModel(if1Addr)) begin
          miscompares++;
          $display("[TB] FAIL b2b_irdata: got %h expected %h", if1Rdata, memModel(if1Addr));
        end
        if1Addr = if1Addr + 32'd4;
      end
      expectD = !expectD;
      tick();
    end
    if1Req = 1'b0;
    d1Req = 1'b0;
    tick();
    tick();
    vectors++;
    if (mem1En !== 1'b0 || busy1 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_idle: got en=%b busy=%b, expected 0 0", mem1En, busy1);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    ifReq = 1'b0; ifAddr = 32'h0;
    dReq = 1'b0; dWe = 1'b0; dAddr = 32'h0; dWdata = 32'h0;
    if1Req = 1'b0; if1Addr = 32'h0;
    d1Req = 1'b0; d1Addr = 32'h0;

    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_alternation();
    test_store();
    test_reset_mid_access();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
